// File: rtl/cust_ram_pkg.sv
// Shared constants and helpers for the multi-read-port register-file RAM.
package cust_ram_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Address width for a given depth, never narrower than one bit.
  function automatic int addr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cust_ram_rd_pipe.sv
// One read port's response pipeline: S1 always, S2 only when RD_LAT is 2.
// Data and hit hold their last values while no response is in a stage.
module cust_ram_rd_pipe #(
  parameter int DATA_W = 771,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              src_hit,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  typedef struct packed {
    logic              v;
    logic              hit;
    logic [DATA_W-1:0] d;
  } rd_stage_t;

  rd_stage_t s1;
  rd_stage_t s_out;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1 <= '0;
    end else begin
      s1.v <= req;
      if (req) begin
        s1.hit <= src_hit;
        s1.d   <= src_data;
      end
    end
  end

  if (RD_LAT == 2) begin : g_s2
    rd_stage_t s2;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        s2 <= '0;
      end else begin
        s2.v <= s1.v;
        if (s1.v) begin
          s2.hit <= s1.hit;
          s2.d   <= s1.d;
        end
      end
    end

    assign s_out = s2;
  end else begin : g_s1_only
    assign s_out = s1;
  end

  assign valid = s_out.v;
  assign hit   = s_out.hit;
  assign data  = s_out.d;

endmodule

// File: rtl/cust_ram_mrport.sv
// 1-write / N-read register-file RAM with per-entry valid tracking, bulk
// clear, selectable read-during-write ordering and a 1- or 2-cycle read pipe.
module cust_ram_mrport
  import cust_ram_pkg::*;
#(
  parameter int DATA_W      = 771,
  parameter int DEPTH       = 8,
  parameter int NUM_RD      = 2,
  parameter int RD_LAT      = 1,
  parameter int WRITE_FIRST = 0,
  parameter int AW          = addr_w(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clear_all,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_hit
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("cust_ram_mrport: RD_LAT must be 1 or 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic              wr_ok;

  assign wr_ok = wr_en && (int'(wr_addr) < DEPTH);

  // NOTE: the data array has no reset; only the valid bits do, so the array
  // maps onto plain storage and consumers rely on rd_hit for freshness.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // A write in the same cycle as a clear wins for its own entry.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld <= '0;
    end else begin
      if (clear_all) vld <= '0;
      if (wr_ok)     vld[wr_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]     addr;
    logic              in_range;
    logic              bypass;
    logic [DATA_W-1:0] sel_data;
    logic              sel_hit;

    assign addr     = rd_addr[p*AW +: AW];
    assign in_range = int'(addr) < DEPTH;
    assign bypass   = (WRITE_FIRST != 0) && wr_ok && (wr_addr == addr);

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
      sel_data = '0;
      sel_hit  = 1'b0;
      if (bypass) begin
        sel_data = wr_data;
        sel_hit  = 1'b1;
      end else if (in_range) begin
        sel_data = mem[addr];
        sel_hit  = vld[addr];
      end
    end

    cust_ram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
    ) u_pipe (
      .clock    (clock),
      .reset_n  (reset_n),
      .req      (rd_en[p]),
      .src_hit  (sel_hit),
      .src_data (sel_data),
      .valid    (rd_valid[p]),
      .hit      (rd_hit[p]),
      .data     (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_cust_ram_mrport.sv
// Bench for cust_ram_mrport: three parameterisations share one stimulus
// stream and are compared every cycle against a table-level model.
module tb_cust_ram_mrport;

  localparam int DW  = 32;
  localparam int ND  = 3;   // 0: D8 L1 read-first, 1: D8 L2 write-first, 2: D6 L1
  localparam int NR  = 2;
  localparam int AWB = 3;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [AWB-1:0]    wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              clear_all = 1'b0;
  logic [NR-1:0]     rd_en = '0;
  logic [NR*AWB-1:0] rd_addr = '0;

  logic [NR*DW-1:0] rd_data_a, rd_data_b, rd_data_c;
  logic [NR-1:0]    rd_valid_a, rd_valid_b, rd_valid_c;
  logic [NR-1:0]    rd_hit_a, rd_hit_b, rd_hit_c;

  always #5 clock = ~clock;

  cust_ram_mrport #(.DATA_W(DW), .DEPTH(8), .NUM_RD(NR), .RD_LAT(1), .WRITE_FIRST(0)) u_a (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_all(clear_all), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_hit(rd_hit_a));

  cust_ram_mrport #(.DATA_W(DW), .DEPTH(8), .NUM_RD(NR), .RD_LAT(2), .WRITE_FIRST(1)) u_b (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_all(clear_all), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_hit(rd_hit_b));

  cust_ram_mrport #(.DATA_W(DW), .DEPTH(6), .NUM_RD(NR), .RD_LAT(1), .WRITE_FIRST(0)) u_c (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_all(clear_all), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_c), .rd_valid(rd_valid_c), .rd_hit(rd_hit_c));

  logic [NR*DW-1:0] od [ND];
  logic [NR-1:0]    ov [ND];
  logic [NR-1:0]    oh [ND];
  assign od[0] = rd_data_a;  assign od[1] = rd_data_b;  assign od[2] = rd_data_c;
  assign ov[0] = rd_valid_a; assign ov[1] = rd_valid_b; assign ov[2] = rd_valid_c;
  assign oh[0] = rd_hit_a;   assign oh[1] = rd_hit_b;   assign oh[2] = rd_hit_c;

  function automatic int dep(input int d); return (d == 2) ? 6 : 8; endfunction
  function automatic int lat(input int d); return (d == 1) ? 2 : 1; endfunction
  function automatic bit wf(input int d);  return d == 1;           endfunction

  typedef struct {
    bit            we;
    int            wa;
    logic [DW-1:0] wd;
    bit            clr;
    bit [1:0]      re;
    int            ra0;
    int            ra1;
    bit            rst;
  } stim_t;

  function automatic stim_t mk(input bit we, input int wa, input logic [DW-1:0] wd,
                               input bit clr, input bit [1:0] re, input int ra0,
                               input int ra1, input bit rst);
    stim_t s;
    s.we = we; s.wa = wa; s.wd = wd; s.clr = clr;
    s.re = re; s.ra0 = ra0; s.ra1 = ra1; s.rst = rst;
    return s;
  endfunction

  // Model: RAM contents as tables, and responses booked by their due cycle.
  logic [DW-1:0] m_mem   [ND][8];
  bit            m_known [ND][8];
  bit            m_vld   [ND][8];
  bit            e_v  [ND][NR][4];
  logic [DW-1:0] e_d  [ND][NR][4];
  bit            e_dk [ND][NR][4];
  bit            e_h  [ND][NR][4];
  logic [DW-1:0] h_d  [ND][NR];
  bit            h_dk [ND][NR];
  bit            h_h  [ND][NR];
  bit            x_v  [ND][NR];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  stim_t         sq[$];

  task automatic step(input stim_t s);
    wr_en     = s.we;
    wr_addr   = AWB'(s.wa);
    wr_data   = s.wd;
    clear_all = s.clr;
    rd_en     = s.re;
    rd_addr   = {AWB'(s.ra1), AWB'(s.ra0)};
    reset_n   = !s.rst;
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < NR; p++) begin
        if (s.re[p]) begin
          int a;
          int sl;
          a  = (p == 1) ? s.ra1 : s.ra0;
          sl = (cyc + lat(d)) % 4;
          e_v[d][p][sl] = 1'b1;
          if (a >= dep(d)) begin
            e_d[d][p][sl] = '0; e_dk[d][p][sl] = 1'b1; e_h[d][p][sl] = 1'b0;
          end else if (wf(d) && s.we && s.wa == a) begin
            e_d[d][p][sl] = s.wd; e_dk[d][p][sl] = 1'b1; e_h[d][p][sl] = 1'b1;
          end else begin
            e_d[d][p][sl]  = m_mem[d][a];
            e_dk[d][p][sl] = m_known[d][a];
            e_h[d][p][sl]  = m_vld[d][a];
          end
        end
      end
      if (s.clr || s.rst)
        for (int i = 0; i < 8; i++) m_vld[d][i] = 1'b0;
      if (s.we && s.wa < dep(d)) begin
        m_mem[d][s.wa]   = s.wd;
        m_known[d][s.wa] = 1'b1;
        if (!s.rst) m_vld[d][s.wa] = 1'b1;
      end
      if (s.rst) begin
        for (int p = 0; p < NR; p++) begin
          for (int k = 0; k < 4; k++) e_v[d][p][k] = 1'b0;
          h_d[d][p] = '0; h_dk[d][p] = 1'b1; h_h[d][p] = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < NR; p++) begin
        x_v[d][p] = e_v[d][p][cyc % 4];
        if (x_v[d][p]) begin
          h_d[d][p]  = e_d[d][p][cyc % 4];
          h_dk[d][p] = e_dk[d][p][cyc % 4];
          h_h[d][p]  = e_h[d][p][cyc % 4];
          e_v[d][p][cyc % 4] = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1));
    sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1));
    foreach (sq[i]) begin
      step(sq[i]);
      for (int d = 0; d < ND; d++)
        for (int p = 0; p < NR; p++) begin
          n_chk++;
          if (ov[d][p] !== 1'b0 || oh[d][p] !== 1'b0 || od[d][p*DW +: DW] !== '0)
            $display("FAIL reset dut%0d port%0d: valid/hit/data got %b/%b/%h want 0/0/0",
                     d, p, ov[d][p], oh[d][p], od[d][p*DW +: DW]);
          else n_pass++;
        end
    end
    sq.delete();
  endtask

  task automatic run_queue(input string tag);
    foreach (sq[i]) begin
      step(sq[i]);
      for (int d = 0; d < ND; d++)
        for (int p = 0; p < NR; p++) begin
          n_chk++;
          if (ov[d][p] !== x_v[d][p] || oh[d][p] !== h_h[d][p] ||
              (h_dk[d][p] && od[d][p*DW +: DW] !== h_d[d][p]))
            $display("FAIL %s dut%0d port%0d cyc%0d: valid/hit/data got %b/%b/%h want %b/%b/%h",
                     tag, d, p, cyc, ov[d][p], oh[d][p], od[d][p*DW +: DW],
                     x_v[d][p], h_h[d][p], h_d[d][p]);
          else n_pass++;
        end
    end
    sq.delete();
  endtask

  task automatic test_basic();
    sq.push_back(mk(0, 0, 0, 0, 2'b01, 3, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    sq.push_back(mk(1, 3, 32'h1A5, 0, 2'b00, 0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b01, 3, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    run_queue("basic");
    n_chk++;
    if (od[0][DW-1:0] !== 32'h1A5 || oh[0][0] !== 1'b1)
      $display("FAIL basic_hold data/hit got %h/%b want 000001a5/1", od[0][DW-1:0], oh[0][0]);
    else n_pass++;
  endtask

  task automatic test_rdw();
    sq.push_back(mk(1, 5, 32'hAA, 0, 2'b00, 0, 0, 0));
    sq.push_back(mk(1, 5, 32'hBB, 0, 2'b11, 5, 5, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b11, 5, 5, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    run_queue("rdw");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) sq.push_back(mk(1, i, 32'h100 + i, 0, 2'b00, 0, 0, 0));
    for (int i = 0; i < 4; i++) sq.push_back(mk(0, 0, 0, 0, 2'b11, i, 3 - i, 0));
    for (int i = 0; i < 2; i++) sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    run_queue("b2b");
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) sq.push_back(mk(1, i, $urandom, 0, 2'b00, 0, 0, 0));
    sq.push_back(mk(1, 6, 32'h66, 1, 2'b00, 0, 0, 0));
    for (int i = 0; i < 8; i++) sq.push_back(mk(0, 0, 0, 0, 2'b11, i, 7 - i, 0));
    for (int i = 0; i < 2; i++) sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    run_queue("clear");
  endtask

  task automatic test_oob();
    sq.push_back(mk(1, 7, 32'hDEAD, 0, 2'b00, 0, 0, 0));
    sq.push_back(mk(1, 5, 32'h55, 0, 2'b00, 0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b11, 7, 5, 0));
    for (int i = 0; i < 2; i++) sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    run_queue("oob");
    n_chk++;
    if (od[2][DW-1:0] !== '0 || oh[2][0] !== 1'b0 || od[2][DW +: DW] !== 32'h55 || oh[2][1] !== 1'b1)
      $display("FAIL oob_d6 p0 data/hit %h/%b want 0/0, p1 data/hit %h/%b want 00000055/1",
               od[2][DW-1:0], oh[2][0], od[2][DW +: DW], oh[2][1]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      sq.push_back(mk(1'($urandom), int'($urandom_range(7)), $urandom,
                      $urandom_range(15) == 0, 2'($urandom),
                      int'($urandom_range(7)), int'($urandom_range(7)), 0));
    for (int i = 0; i < 2; i++) sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    run_queue("random");
  endtask

  task automatic test_reset_midread();
    sq.push_back(mk(0, 0, 0, 0, 2'b11, 1, 2, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b11, 3, 4, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b11, 5, 6, 1));
    sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    for (int i = 0; i < 8; i++) sq.push_back(mk(0, 0, 0, 0, 2'b11, i, 7 - i, 0));
    for (int i = 0; i < 2; i++) sq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    run_queue("reset_midread");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rdw();
    test_back_to_back();
    test_clear();
    test_oob();
    test_random();
    test_reset_midread();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cust_ram_mrport.md
Name: cust_ram_mrport

Overview:
- Parametrised 1-write / N-read register-file RAM for the nvme_ctrl custom AFU. Successor to the fixed 771-bit x 8-entry, 2-read-port buffer.
- Adds:
  - configurable width, depth and read-port count
  - per-port read enables with a registered valid pipeline (1 or 2 cycles)
  - selectable read-during-write ordering
  - per-entry written/valid tracking with a bulk clear
- Sits between the command/completion staging logic and its consumers, which use rd_hit to detect stale slots.

Parameters:
- DATA_W, 771, entry width in bits.
- DEPTH, 8, number of entries; ≥2, need not be a power of two.
- NUM_RD, 2, number of independent read ports; ≥1.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2. Any other value is an elaboration error.
- WRITE_FIRST, 0. 0 = a same-cycle read returns the old contents. 1 = it returns the data being written.
- AW, max(1,$clog2(DEPTH)), address width. Derived; do not override.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  DATA_W  write data
- clear_all  in  1  invalidate every entry in one cycle
- rd_en  in  NUM_RD  per-port read strobe
- rd_addr  in  NUM_RD*AW  port p address in bits [p*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  port p data in bits [p*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  port p response valid
- rd_hit  out  NUM_RD  addressed entry was valid when it was read

Behaviour:
- Storage:
  - The data array is not reset; contents are undefined until written.
  - The valid vector vld[DEPTH] resets to all-0.
- Reset (reset_n=0 at a clock edge):
  - vld, rd_valid, rd_hit and every pipeline stage register clear to 0.
  - rd_data clears to 0.
  - Reset asserted mid-read drops the in-flight responses; no rd_valid pulse follows.
- Write:
  - wr_en=1 with wr_addr<DEPTH: mem[wr_addr]<=wr_data and vld[wr_addr]<=1 at the edge.
  - wr_addr≥DEPTH: the write is ignored.
- Clear:
  - clear_all=1 zeroes all vld bits at the edge; data is untouched.
  - Same cycle as wr_en: the written entry ends with vld=1, all others end with 0.
- Read, for each port p independently:
  - Stage S1 is registered at the edge where rd_en[p]=1. It captures data=mem[addr], hit=vld[addr] and v=1.
  - RD_LAT=1: S1 drives the outputs directly. rd_valid[p] is high exactly one cycle after the rd_en[p] cycle.
  - RD_LAT=2: one additional register stage. Valid appears two cycles after rd_en.
  - Full throughput: back-to-back rd_en on every cycle produces back-to-back rd_valid.
  - rd_en[p]=0: the valid bit in that stage is 0. rd_data[p] and rd_hit[p] hold their last values, so the outputs do not toggle.
  - rd_addr≥DEPTH: the read returns rd_data=0, rd_hit=0 and rd_valid=1.
- Read-during-write, same address, same cycle:
  - WRITE_FIRST=0: returns the old data and the old vld bit.
  - WRITE_FIRST=1: returns wr_data with hit=1.
  - Reads of other addresses are unaffected.
- Read with clear_all in the same cycle: returns the pre-clear vld. If WRITE_FIRST=1 and the write addresses the read entry, hit=1.
- Multiple ports may read the same address in the same cycle; each receives identical data.
- No backpressure. Consumers must accept rd_valid when it is asserted.

Decomposition:
- Package cust_ram_pkg holds:
  - the function addr_w(depth), returning max(1,clog2(depth))
  - the localparams RD_LAT_MIN=1 and RD_LAT_MAX=2
  - the typedef rd_stage_t {logic v; logic hit; logic [DATA_W-1:0] d}, instantiated via a parametrised struct macro or per-module typedef
- Sub-module cust_ram_rd_pipe: one read port's S1/S2 pipeline including the hold-when-idle logic. Generated NUM_RD times.
- The top level owns mem, vld, the write/clear logic and the bypass mux.

Test Plan:
1. Reset, then read addr 3 on port 0 → 1 cycle later rd_valid[0]=1, rd_hit[0]=0. Write 0x1A5 to addr 3, read again → rd_data[0]=0x1A5, rd_hit=1.
2. WRITE_FIRST=0: mem[5]=0xAA, then same cycle wr 5←0xBB and rd 5 → rd_data=0xAA. Next read → 0xBB. With WRITE_FIRST=1, the same-cycle read → 0xBB, hit=1.
3. RD_LAT=2, NUM_RD=2: port0 reads 0,1,2,3 back-to-back while port1 reads 3,2,1,0. Outputs appear 2 cycles later, one per cycle, with data matching per port and no gaps.
4. Fill all 8 entries, assert clear_all with wr_en to addr 6 → subsequent reads give rd_hit=1 only for addr 6. Data of addr 2 is still returned with hit=0.
5. DEPTH=6: write addr 7 → ignored. Read addr 7 → rd_valid=1, rd_data=0, rd_hit=0. Read addr 5 is unaffected.
6. Issue reads on 2 consecutive cycles, assert reset_n=0 on the next edge → no rd_valid afterwards. All outputs are 0 and all vld bits are 0 after reset.
